// File: rtl/spi_mem_master_pkg.sv
// rtl/spi_mem_master_pkg.sv - state encodings and frame constants shared by spi_mem_master
package spi_mem_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam int   FRAME_W = 16;
  localparam int   EDGE_W  = 5;
  localparam logic RW_READ = 1'b1;

endpackage

// File: rtl/spi_mem_master_sclk_gen.sv
// rtl/spi_mem_master_sclk_gen.sv - sclk divider with rise/fall tick pulses, active only while enabled
module spi_mem_master_sclk_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div;
  logic             wrap;

  assign wrap      = en && (div == DIV_W'(CLK_DIV - 1));
  assign rise_tick = wrap && !sclk;
  assign fall_tick = wrap && sclk;

  // Held at zero while disabled so every SHIFT entry starts a fresh half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      div  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      div  <= '0;
      sclk <= !sclk;
    end else begin
      div  <= div + 1'b1;
    end
  end

endmodule

// File: rtl/spi_mem_master.sv
// rtl/spi_mem_master.sv - SPI master sequencing one 16-bit read/write frame per accepted request
module spi_mem_master
  import spi_mem_master_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int CS_GAP  = 8,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("spi_mem_master: CLK_DIV must be at least 2");
  end
  if (ADDR_W + 1 + DATA_W != FRAME_W) begin : g_bad_frame
    $error("spi_mem_master: ADDR_W + 1 + DATA_W must equal FRAME_W");
  end

  state_e             state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic [EDGE_W-1:0]  edge_cnt;
  logic [FRAME_W-2:0] tx_sh;
  logic [DATA_W-1:0]  rx_sh;
  logic               rw_q;
  logic               rise_tick, fall_tick, last_edge;

  spi_mem_master_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state == ST_SHIFT),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  assign last_edge = fall_tick && (edge_cnt == EDGE_W'(2 * FRAME_W - 1));
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_DONE);

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (req_valid) next_state = ST_SETUP;
      ST_SETUP: if (cnt == CNT_W'(CLK_DIV - 1)) next_state = ST_SHIFT;
      ST_SHIFT: if (last_edge) next_state = ST_HOLD;
      ST_HOLD:  if (cnt == CNT_W'(CLK_DIV - 1)) next_state = ST_GAP;
      ST_GAP:   if (cnt == CNT_W'(CS_GAP - 1)) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      edge_cnt  <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      rw_q      <= 1'b0;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= next_state;
      cnt   <= (next_state != state) ? '0 : cnt + 1'b1;
      cs_n  <= !(next_state inside {ST_SETUP, ST_SHIFT, ST_HOLD});

      if (state != ST_SHIFT)
        edge_cnt <= '0;
      else if (rise_tick || fall_tick)
        edge_cnt <= edge_cnt + 1'b1;

      // The MSB goes straight to mosi; tx_sh only holds the bits still to send.
      if (state == ST_IDLE && req_valid) begin
        rw_q  <= req_rw;
        mosi  <= req_addr[ADDR_W-1];
        tx_sh <= {req_addr[ADDR_W-2:0], req_rw, req_wdata & {DATA_W{req_rw != RW_READ}}};
      end else if (fall_tick && !last_edge) begin
        mosi  <= tx_sh[FRAME_W-2];
        tx_sh <= {tx_sh[FRAME_W-3:0], 1'b0};
      end else if (next_state == ST_GAP) begin
        mosi  <= 1'b0;
      end

      if (rise_tick)
        rx_sh <= {rx_sh[DATA_W-2:0], miso};

      if (state == ST_GAP && next_state == ST_DONE && rw_q == RW_READ)
        rsp_rdata <= rx_sh;
    end
  end

endmodule

// File: tb/tb_spi_mem_master.sv
// tb/tb_spi_mem_master.sv - directed self-checking bench for spi_mem_master with a behavioural SPI memory slave
module tb_spi_mem_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_rw = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid, busy, sclk, cs_n, mosi;
  logic       miso = 1'b0;
  logic [7:0] rsp_rdata;

  logic       req_valid_f = 1'b0, req_rw_f = 1'b0;
  logic [6:0] req_addr_f = '0;
  logic [7:0] req_wdata_f = '0;
  logic       req_ready_f, rsp_valid_f, busy_f, sclk_f, cs_n_f, mosi_f;
  logic [7:0] rsp_rdata_f;

  int nchecks = 0, nerrors = 0;

  always #5 clk = ~clk;

  spi_mem_master dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_mem_master #(.CLK_DIV(2), .CS_GAP(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_f), .req_ready(req_ready_f),
    .req_rw(req_rw_f), .req_addr(req_addr_f), .req_wdata(req_wdata_f),
    .rsp_valid(rsp_valid_f), .rsp_rdata(rsp_rdata_f), .busy(busy_f),
    .sclk(sclk_f), .cs_n(cs_n_f), .mosi(mosi_f), .miso(1'b0)
  );

  // Mode-0 memory slave: samples mosi on sclk rise, shifts read data out on sclk fall.
  logic [7:0]  mem [128];
  logic [15:0] s_rx = '0;
  logic [7:0]  s_tx = '0;
  int          s_bits = 0;

  always @(negedge cs_n) s_bits = 0;

  always @(posedge sclk) begin
    s_rx = {s_rx[14:0], mosi};
    s_bits++;
    if (s_bits == 8 && s_rx[0]) s_tx = mem[s_rx[7:1]];
    if (s_bits == 16 && !s_rx[8]) mem[s_rx[15:9]] = s_rx[7:0];
  end

  always @(negedge sclk) begin
    if (!cs_n && s_bits >= 8 && s_bits < 16) begin
      miso = s_tx[7];
      s_tx = {s_tx[6:0], 1'b0};
    end else begin
      miso = 1'b0;
    end
  end

  logic [15:0] cap_f = '0;
  int          rises_f = 0, hi_f = 0;

  always @(negedge cs_n_f) begin
    rises_f = 0;
    hi_f    = 0;
  end

  always @(posedge sclk_f) begin
    cap_f = {cap_f[14:0], mosi_f};
    rises_f++;
  end

  int         ncyc = 0, acc_cnt = 0, acc_cyc = 0, rsp_cnt = 0, rsp_cyc = 0;
  int         dbl_rsp = 0, ready_cnt = 0, hi_run = 0, gap_last = 0;
  int         acc_cnt_f = 0, acc_cyc_f = 0, rsp_cnt_f = 0, rsp_cyc_f = 0;
  logic       prev_rsp = 1'b0, prev_cs = 1'b1;
  logic [7:0] rsp_data = '0;

  always @(negedge clk) begin
    ncyc++;
    if (rst_n && req_valid && req_ready) begin acc_cnt++; acc_cyc = ncyc; end
    if (rsp_valid) begin rsp_cnt++; rsp_cyc = ncyc; rsp_data = rsp_rdata; end
    if (rsp_valid && prev_rsp) dbl_rsp++;
    prev_rsp = rsp_valid;
    if (req_ready) ready_cnt++;
    if (!cs_n && prev_cs) gap_last = hi_run;
    hi_run  = cs_n ? hi_run + 1 : 0;
    prev_cs = cs_n;
    if (rst_n && req_valid_f && req_ready_f) begin acc_cnt_f++; acc_cyc_f = ncyc; end
    if (rsp_valid_f) begin rsp_cnt_f++; rsp_cyc_f = ncyc; end
    if (!cs_n_f && sclk_f) hi_f++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic rw, input logic [6:0] addr,
                         input logic [7:0] wdata, output int lat);
    int a0, r0, n;
    a0 = acc_cnt;
    r0 = rsp_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (acc_cnt == a0 && n < 100) begin @(posedge clk); n++; end
    #1;
    req_valid = 1'b0; req_rw = ~rw; req_addr = ~addr; req_wdata = ~wdata;
    check({tag, "_accept"}, acc_cnt - a0, 1);
    n = 0;
    while (rsp_cnt == r0 && n < 2000) begin @(posedge clk); n++; end
    check({tag, "_rsp_seen"}, rsp_cnt - r0, 1);
    lat = rsp_cyc - acc_cyc;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int lat, a0, r0, n, rdy0, rsp_first;
    for (int i = 0; i < 128; i++) mem[i] = 8'hFF;

    repeat (3) @(posedge clk);
    #1;
    check("reset_sclk", sclk, 0);
    check("reset_cs_n", cs_n, 1);
    check("reset_mosi", mosi, 0);
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;

    // Reset asserted while the frame is shifting
    a0 = acc_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h33; req_wdata = 8'h5A;
    n = 0;
    while (acc_cnt == a0 && n < 100) begin @(posedge clk); n++; end
    #1 req_valid = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    check("pre_rst_cs_n", cs_n, 0);
    check("pre_rst_sclk", sclk, 1);
    rst_n = 1'b0;
    #1;
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mosi", mosi, 0);
    r0 = rsp_cnt;
    @(negedge clk) rst_n = 1'b1;
    repeat (700) @(posedge clk);
    check("rst_no_rsp", rsp_cnt - r0, 0);

    // Write 0x15 <= 0xA5
    run_req("wr", 1'b0, 7'h15, 8'hA5, lat);
    check("wr_latency", lat, 553);
    check("wr_mosi_frame", s_rx, 16'h2AA5);
    check("wr_rise_edges", s_bits, 16);
    check("wr_mem", mem[7'h15], 8'hA5);

    // Read 0x15 with slave returning 0x3C
    mem[7'h15] = 8'h3C;
    run_req("rd", 1'b1, 7'h15, 8'hEE, lat);
    check("rd_latency", lat, 553);
    check("rd_data", rsp_data, 8'h3C);
    check("rd_mosi_frame", s_rx, 16'h2B00);

    // req_valid held high across two writes
    a0 = acc_cnt;
    r0 = rsp_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h01; req_wdata = 8'h11;
    n = 0;
    while (acc_cnt == a0 && n < 100) begin @(posedge clk); n++; end
    #1;
    req_addr = 7'h02; req_wdata = 8'h22;
    rdy0 = ready_cnt;
    n = 0;
    while (rsp_cnt == r0 && n < 2000) begin @(posedge clk); n++; end
    check("b2b_first_rsp", rsp_cnt - r0, 1);
    check("b2b_ready_low", ready_cnt - rdy0, 0);
    check("b2b_rdata_kept", rsp_data, 8'h3C);
    rsp_first = rsp_cyc;
    n = 0;
    while (acc_cnt < a0 + 2 && n < 100) begin @(posedge clk); n++; end
    #1 req_valid = 1'b0;
    check("b2b_second_accept", acc_cyc - rsp_first, 1);
    n = 0;
    while (rsp_cnt < r0 + 2 && n < 2000) begin @(posedge clk); n++; end
    check("b2b_second_rsp", rsp_cnt - r0, 2);
    check("b2b_cs_gap", gap_last >= 8, 1);
    check("b2b_mem1", mem[7'h01], 8'h11);
    check("b2b_mem2", mem[7'h02], 8'h22);

    // Memory round trips at the address extremes
    run_req("wr7f", 1'b0, 7'h7F, 8'hC3, lat);
    run_req("rd7f", 1'b1, 7'h7F, 8'h00, lat);
    check("rd7f_data", rsp_data, 8'hC3);
    run_req("wr00", 1'b0, 7'h00, 8'h00, lat);
    run_req("rd00", 1'b1, 7'h00, 8'hFF, lat);
    check("rd00_data", rsp_data, 8'h00);

    // Minimum divider instance
    a0 = acc_cnt_f;
    r0 = rsp_cnt_f;
    @(posedge clk); #1;
    req_valid_f = 1'b1; req_rw_f = 1'b0; req_addr_f = 7'h2A; req_wdata_f = 8'h55;
    n = 0;
    while (acc_cnt_f == a0 && n < 100) begin @(posedge clk); n++; end
    #1 req_valid_f = 1'b0;
    n = 0;
    while (rsp_cnt_f == r0 && n < 500) begin @(posedge clk); n++; end
    check("fast_rsp_seen", rsp_cnt_f - r0, 1);
    check("fast_latency", rsp_cyc_f - acc_cyc_f, 70);
    check("fast_rise_edges", rises_f, 16);
    check("fast_sclk_high_cycles", hi_f, 32);
    check("fast_mosi_frame", cap_f, 16'h5455);

    repeat (4) @(posedge clk);
    check("single_cycle_rsp", dbl_rsp, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
